// File: rtl/xor4_bist.sv
// Built-in self test for a 4-input XOR: sweeps all 16 input vectors, holds each
// for HOLD clocks, and counts and captures mismatches on the z2 response.
module xor4_bist #(
   parameter int unsigned HOLD = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       z2,
   output logic       x0,
   output logic       x1,
   output logic       x2,
   output logic       x3,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_cnt,
   output logic       fail_valid,
   output logic [3:0] fail_vec
);

   localparam int unsigned HCNT_W = 8;
   localparam int unsigned VEC_W  = 4;
   localparam int unsigned ERR_W  = 5;

   typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

   state_t             state, state_n;
   logic [VEC_W-1:0]   vec, vec_n;
   logic [HCNT_W-1:0]  hcnt, hcnt_n;
   logic [ERR_W-1:0]   err_n;
   logic               fail_valid_n;
   logic [VEC_W-1:0]   fail_vec_n;
   logic               sample_c;
   logic               mismatch_c;

   assign sample_c   = (hcnt == HCNT_W'(HOLD - 1));
   assign mismatch_c = (z2 != (^vec));

   // Next-state and result bookkeeping
   always_comb begin
      state_n      = state;
      vec_n        = vec;
      hcnt_n       = hcnt;
      err_n        = err_cnt;
      fail_valid_n = fail_valid;
      fail_vec_n   = fail_vec;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n      = APPLY;
               vec_n        = '0;
               hcnt_n       = '0;
               err_n        = '0;
               fail_valid_n = 1'b0;
               fail_vec_n   = '0;
            end
         end
         APPLY: begin
            hcnt_n = hcnt + HCNT_W'(1);
            if (sample_c) begin
               if (mismatch_c) begin
                  err_n = err_cnt + ERR_W'(1);
                  if (!fail_valid) begin
                     fail_valid_n = 1'b1;
                     fail_vec_n   = vec;
                  end
               end
               hcnt_n = '0;
               if (vec == VEC_W'(15)) state_n = DONE;
               else                   vec_n   = vec + VEC_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, counters and registered outputs (decoded from next state)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         vec        <= '0;
         hcnt       <= '0;
         err_cnt    <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         {x0, x1, x2, x3} <= '0;
      end else begin
         state      <= state_n;
         vec        <= vec_n;
         hcnt       <= hcnt_n;
         err_cnt    <= err_n;
         fail_valid <= fail_valid_n;
         fail_vec   <= fail_vec_n;
         busy       <= (state_n == APPLY);
         done       <= (state_n == DONE);
         pass       <= (state_n == DONE) && (err_n == '0);
         {x0, x1, x2, x3} <= (state_n == APPLY) ? vec_n : '0;
      end
   end

endmodule

// File: doc/xor4_bist.md
XOR4_BIST -- requirements
Module: xor4_bist

Interface
REQ-001 Parameter: HOLD, default 2, clocks each test vector is applied to the xor4 under test (legal range 1..255).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  run request, sampled on rising clk.
REQ-005 x0, x1, x2, x3  output  1 each  stimulus to the xor4 inputs of the same names.
REQ-006 z2  input  1  xor4 output under test.
REQ-007 busy  output  1  high while a run is in progress.
REQ-008 done  output  1  high while results of a completed run are held.
REQ-009 pass  output  1  high when done=1 and no mismatch was found.
REQ-010 err_cnt  output  5  number of mismatching vectors in the current or last run (0..16).
REQ-011 fail_valid  output  1  high once at least one mismatch has been captured.
REQ-012 fail_vec  output  4  {x0,x1,x2,x3} of the first mismatching vector.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, APPLY, DONE.
REQ-014 IDLE: busy=0, done=0, x0..x3=0; start=1 -> APPLY, vector counter vec=0, hold counter hcnt=0, err_cnt=0, fail_valid=0, fail_vec=0.
REQ-015 APPLY: busy=1, done=0; {x0,x1,x2,x3}=vec, with x0 as MSB and x3 as LSB; vec counts 0..15 in ascending order.
REQ-016 APPLY: hcnt increments each clock; when hcnt=HOLD-1 the block samples z2 in that cycle and compares it with expected = x0^x1^x2^x3.
REQ-017 Mismatch at a sample: err_cnt increments by 1 on the next edge; if fail_valid=0, fail_vec<=vec and fail_valid<=1 on that edge. Later mismatches SHALL NOT change fail_vec.
REQ-018 Sample with vec<15: vec<=vec+1, hcnt<=0. Sample with vec=15: go to DONE, with no wrap to 0.
REQ-019 DONE: busy=0, done=1, x0..x3=0; err_cnt, fail_valid and fail_vec held; pass=(err_cnt==0).
REQ-020 pass SHALL be 0 in every state except DONE.
REQ-021 DONE with start=1: restart directly into APPLY and clear results as in REQ-014.
REQ-022 start=1 while in APPLY SHALL be ignored; the run continues unaffected.
REQ-023 Timing: start seen at edge N -> busy=1 from N+1; exactly 16*HOLD clocks in APPLY; done=1 on the clock after the final sample.
REQ-024 err_cnt SHALL be 5 bits wide so the maximum value of 16 cannot overflow; no saturation logic is required.
REQ-025 z2 is treated as synchronous to clk; no input synchronizer is used.

Reset
REQ-026 rst=1 at any time, including mid-run, SHALL immediately force: state=IDLE, vec=0, hcnt=0, x0..x3=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, fail_vec=0.
REQ-027 After rst deasserts, the block stays in IDLE until start=1 is sampled; there is no auto-run.

Verification
REQ-028 Correct DUT (z2=x0^x1^x2^x3), HOLD=2, 1-clock start pulse -> busy high 32 clocks, then done=1, pass=1, err_cnt=0, fail_valid=0.
REQ-029 z2 stuck at 0 -> done=1, pass=0, err_cnt=8, fail_valid=1, fail_vec=4'b0001.
REQ-030 z2 inverted parity -> err_cnt=16, fail_vec=4'b0000, pass=0; also checks the 5-bit counter width.
REQ-031 rst pulsed while vec=7 -> all outputs are zero the same cycle; a later start gives a full 32-clock run with correct results.
REQ-032 start held high for the whole run -> APPLY is not restarted (busy stays exactly 32 clocks); in DONE the run restarts, clearing err_cnt from 8 to 0 on entry.
REQ-033 HOLD=1, correct DUT -> busy for 16 clocks; x outputs step through 0..15 one per clock; pass=1.
